trig_fire_sched: RTL and testbench
==================================

Name: trig_fire_sched

Overview:
- Central fire scheduler for the trigger board.
- Takes per-condition trigger requests (one bit per trigger number), gates them with run state and prescale, and sequences the output fire pulse and per-fire deadtime.
- Merges near-simultaneous conditions into one event and stamps it with a free-running timestamp.
- Queues event records in a small FWFT buffer for the readout side, with a valid/ready handshake.

Parameters:
- NTRIG, 8: number of trigger conditions.
- OUT_WIDTH, 16: cycles fire_out stays high per event (>=1).
- MERGE_WIN, 4: cycles after fire start during which extra conditions are ORed into the event mask (1..OUT_WIDTH).
- DEPTH, 8: record buffer depth (power of 2).
- TS_W, 56: timestamp width.

Ports:
- clk_adc, in, 1: sole clock.
- rst, in, 1: reset, asynchronous, active-high.
- run_active, in, 1: run gate (board run input); requests are ignored while low.
- trig_req, in, NTRIG: per-condition request level, sampled every cycle.
- trig_en, in, NTRIG: enable mask (trigger-number select).
- pass_prescale, in, 1: prescale pass for this cycle.
- dead_time, in, 8: deadtime in cycles after the fire pulse.
- ts_clear, in, 1: synchronous clear of timestamp, buffer and drop counter.
- fire_out, out, 1: registered fire pulse to all coax outputs.
- busy, out, 1: high whenever state != IDLE.
- rec_valid, out, 1: buffer non-empty.
- rec_ready, in, 1: consumer accepts the head record.
- rec_mask, out, NTRIG: head record trigger mask.
- rec_time, out, TS_W: head record timestamp.
- rec_count, out, $clog2(DEPTH)+1: records held.
- drop_count, out, 16: records lost to a full buffer; saturates at 16'hFFFF.

Behaviour:
- Reset: state IDLE; ts, buffer pointers, rec_count, drop_count and all internal counters are 0; fire_out = busy = rec_valid = 0.
- ts increments every cycle and wraps modulo 2^TS_W. When ts_clear is high in cycle N, ts = 0 in cycle N+1.
- qual = trig_req & trig_en when run_active && pass_prescale; otherwise qual = 0.
- IDLE: if qual != 0 in cycle N:
  - latch mask = qual and stamp = ts(N);
  - enter FIRE;
  - fire_out is high in cycles N+1 .. N+OUT_WIDTH inclusive.
- FIRE, merge window: during the first MERGE_WIN cycles of FIRE, mask |= qual.
- FIRE, push: in the last merge cycle the record {mask, stamp} is pushed, including any bits ORed in that same cycle.
- FIRE, exit: after OUT_WIDTH cycles, go to DEAD with the counter loaded from dead_time as sampled at that edge. If dead_time == 0, go directly to IDLE.
- DEAD: lasts exactly dead_time cycles, then IDLE. A qual present in the first IDLE cycle fires immediately.
- Dropped requests: requests during FIRE (outside the merge window) and during DEAD are dropped, not queued.
- Buffer:
  - first-word-fall-through; rec_mask/rec_time are valid whenever rec_valid is high;
  - pop when rec_valid && rec_ready;
  - push into a full buffer is discarded and increments drop_count;
  - simultaneous push and pop when full: both succeed, no drop;
  - simultaneous push and pop when empty: push succeeds, nothing popped;
  - pointers wrap modulo DEPTH.
- ts_clear (synchronous):
  - empties the buffer and zeroes drop_count;
  - discards the in-flight record if the push has not yet occurred;
  - does not abort FIRE/DEAD timing.
- Async rst mid-FIRE: fire_out drops immediately and the record is lost.

Optional Feature:
- Macro TRIG_FIRE_SCHED_ROLLING_EN.
- When defined:
  - adds input dorolling (1) and output rec_rolling (1, head record flag);
  - an internal 21-bit autocounter sets a pending rolling request each time bit 20 sets (period 2^20 cycles) while dorolling is high;
  - the pending request is served in IDLE ahead of qual, bypassing trig_en and pass_prescale but still requiring run_active;
  - the served record has mask = 0 and rolling = 1; pending clears when served;
  - a rolling request that occurs while pending is already set is lost.
- When undefined: no extra ports or counter; behaviour is exactly as above.

Decomposition:
- Package trig_fire_pkg: TS_W default constant, state enum {IDLE, FIRE, DEAD}, and a record struct {mask, time, rolling}.
- One sub-module, trig_rec_fifo: parameterised FWFT ring buffer with push/pop, count and full flag. The drop counter stays in the parent.

Test Plan:
1. rst released, trig_en=8'h01, pass_prescale=1, run_active=1, trig_req=8'h01 at ts=100 -> fire_out high 16 cycles starting next cycle; one record with mask=8'h01, time=100.
2. trig_req bit0 at cycle N, bit3 at N+3 (MERGE_WIN=4) -> single record with mask=8'h09; a bit5 request at N+6 is not recorded.
3. dead_time=10 with requests held high -> second fire_out rising edge exactly OUT_WIDTH+10+1 cycles after the first; with dead_time=0 the gap is OUT_WIDTH+1.
4. rec_ready=0 and 10 events -> rec_count=8, drop_count=2; then rec_ready=1 -> records come out in order with timestamps increasing.
5. Push coinciding with pop while full -> rec_count stays 8 and drop_count is unchanged. ts_clear mid-FIRE before the push -> buffer empty, no record, fire_out width still 16.
6. run_active=0 or pass_prescale=0 with trig_req=8'hFF -> no fire, busy=0. With TRIG_FIRE_SCHED_ROLLING_EN and dorolling=1 -> a rolling record every 2^20 cycles with rec_rolling=1 and mask=0.

Source files
------------

// File: rtl/trig_fire_pkg.sv
// trig_fire_pkg: shared constants, scheduler state and event record layout for trig_fire_sched.
package trig_fire_pkg;
  localparam int NTRIG_DEF = 8;
  localparam int TS_W_DEF = 56;
  typedef enum logic [1:0] {IDLE, FIRE, DEAD} state_t;
  typedef struct packed {
    logic [NTRIG_DEF-1:0] mask;
    logic [TS_W_DEF-1:0]  ts;
    logic                 rolling;
  } rec_t;
endpackage

// File: rtl/trig_rec_fifo.sv
// trig_rec_fifo: first-word-fall-through ring buffer; a push into a full buffer lands only if a pop frees a slot that cycle.
module trig_rec_fifo #(
  parameter int W = 64,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_count;
  logic w_wr, w_rd;
  assign count = r_count;
  assign full = r_count == (AW+1)'(DEPTH);
  assign empty = r_count == '0;
  assign w_rd = pop && !empty;
  assign w_wr = push && (!full || w_rd);
  assign dout = r_mem[r_rp];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
      r_count <= '0;
    end else if (clr) begin
      r_wp <= '0;
      r_rp <= '0;
      r_count <= '0;
    end else begin
      r_wp <= r_wp + AW'(w_wr);
      r_rp <= r_rp + AW'(w_rd);
      r_count <= r_count + (AW+1)'(w_wr) - (AW+1)'(w_rd);
    end
  always_ff @(posedge clk)
    if (w_wr && !clr) r_mem[r_wp] <= din;
endmodule

// File: rtl/trig_fire_sched.sv
// trig_fire_sched: gates trigger requests, sequences fire pulse/deadtime, merges conditions and queues timestamped records.
// Optional periodic rolling trigger enabled by defining TRIG_FIRE_SCHED_ROLLING_EN.
module trig_fire_sched import trig_fire_pkg::*; #(
  parameter int NTRIG = NTRIG_DEF,
  parameter int OUT_WIDTH = 16,
  parameter int MERGE_WIN = 4,
  parameter int DEPTH = 8,
  parameter int TS_W = TS_W_DEF
) (
  input  logic                   clk_adc,
  input  logic                   rst,
  input  logic                   run_active,
  input  logic [NTRIG-1:0]       trig_req,
  input  logic [NTRIG-1:0]       trig_en,
  input  logic                   pass_prescale,
  input  logic [7:0]             dead_time,
  input  logic                   ts_clear,
  output logic                   fire_out,
  output logic                   busy,
  output logic                   rec_valid,
  input  logic                   rec_ready,
  output logic [NTRIG-1:0]       rec_mask,
  output logic [TS_W-1:0]        rec_time,
  output logic [$clog2(DEPTH):0] rec_count,
`ifdef TRIG_FIRE_SCHED_ROLLING_EN
  input  logic                   dorolling,
  output logic                   rec_rolling,
`endif
  output logic [15:0]            drop_count
);
  localparam int CW = $clog2(OUT_WIDTH + 1);
  localparam logic [CW-1:0] MW_LAST = CW'(MERGE_WIN - 1);
  localparam logic [CW-1:0] OW_LAST = CW'(OUT_WIDTH - 1);
`ifdef TRIG_FIRE_SCHED_ROLLING_EN
  localparam int RW = NTRIG + TS_W + 1;
`else
  localparam int RW = NTRIG + TS_W;
`endif
  state_t r_state, w_nxt;
  logic r_fire, r_live, r_roll;
  logic [TS_W-1:0] r_ts, r_stamp;
  logic [NTRIG-1:0] r_mask, w_qual, w_mask_m;
  logic [CW-1:0] r_cnt;
  logic [7:0] r_dcnt;
  logic [15:0] r_drop;
  logic w_roll_go, w_start, w_merge, w_push, w_fire_end, w_pop, w_full, w_empty, w_drop;
  logic [RW-1:0] w_din, w_dout;
  assign w_qual = (run_active && pass_prescale) ? trig_req & trig_en : '0;
  assign w_start = r_state == IDLE && (w_qual != '0 || w_roll_go);
  assign w_merge = r_state == FIRE && r_cnt <= MW_LAST && !r_roll;
  assign w_mask_m = w_merge ? r_mask | w_qual : r_mask;
  assign w_push = r_state == FIRE && r_cnt == MW_LAST && r_live;
  assign w_fire_end = r_state == FIRE && r_cnt == OW_LAST;
  assign w_pop = rec_valid && rec_ready;
  assign w_drop = w_push && w_full && !w_pop && !ts_clear;
  assign fire_out = r_fire;
  assign busy = r_state != IDLE;
  assign rec_valid = !w_empty;
  assign rec_time = w_dout[TS_W-1:0];
  assign rec_mask = w_dout[TS_W +: NTRIG];
  assign drop_count = r_drop;
`ifdef TRIG_FIRE_SCHED_ROLLING_EN
  logic [20:0] r_auto;
  logic r_pend;
  assign w_roll_go = r_pend && run_active;
  assign w_din = {r_roll, w_mask_m, r_stamp};
  assign rec_rolling = w_dout[RW-1];
  // Restarting at 1 after bit 20 sets gives a tick every 2^20 cycles.
  always_ff @(posedge clk_adc or posedge rst)
    if (rst) begin
      r_auto <= '0;
      r_pend <= 1'b0;
    end else begin
      r_auto <= r_auto[20] ? 21'd1 : r_auto + 21'd1;
      r_pend <= (r_auto[20] && dorolling) || (r_pend && !(r_state == IDLE && w_roll_go));
    end
`else
  assign w_roll_go = 1'b0;
  assign w_din = {w_mask_m, r_stamp};
`endif
  always_comb
    w_nxt = r_state == IDLE ? (w_start ? FIRE : IDLE) :
            r_state == FIRE ? (w_fire_end ? (dead_time == 8'd0 ? IDLE : DEAD) : FIRE) :
            (r_dcnt == 8'd1 ? IDLE : DEAD);
  always_ff @(posedge clk_adc or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_fire <= 1'b0;
      r_ts <= '0;
      r_cnt <= '0;
      r_dcnt <= '0;
      r_mask <= '0;
      r_stamp <= '0;
      r_live <= 1'b0;
      r_roll <= 1'b0;
      r_drop <= '0;
    end else begin
      r_state <= w_nxt;
      r_fire <= w_nxt == FIRE;
      r_ts <= ts_clear ? '0 : r_ts + 1'b1;
      r_cnt <= r_state == FIRE ? r_cnt + 1'b1 : '0;
      r_dcnt <= w_fire_end ? dead_time : r_state == DEAD ? r_dcnt - 8'd1 : r_dcnt;
      r_drop <= ts_clear ? '0 : (w_drop && r_drop != 16'hFFFF) ? r_drop + 16'd1 : r_drop;
      // A clear before the push point kills the in-flight record but not the pulse timing.
      if (w_start) begin
        r_mask <= w_roll_go ? '0 : w_qual;
        r_stamp <= r_ts;
        r_live <= !ts_clear;
        r_roll <= w_roll_go;
      end else begin
        r_mask <= w_mask_m;
        if (ts_clear) r_live <= 1'b0;
      end
    end
  trig_rec_fifo #(.W(RW), .DEPTH(DEPTH)) u_fifo (
    .clk(clk_adc),
    .rst(rst),
    .clr(ts_clear),
    .push(w_push),
    .pop(w_pop),
    .din(w_din),
    .dout(w_dout),
    .count(rec_count),
    .full(w_full),
    .empty(w_empty)
  );
endmodule

// File: tb/tb_trig_fire_sched.sv
// tb_trig_fire_sched: randomized bench with a cycle-arithmetic reference model and a record scoreboard.
module tb_trig_fire_sched;
  import trig_fire_pkg::*;
  localparam int NTRIG = 8, OUT_WIDTH = 16, MERGE_WIN = 4, DEPTH = 8, TS_W = 56;
  localparam int NCYC = 6000;
  logic clk_adc = 1'b0;
  logic rst, run_active, pass_prescale, ts_clear, rec_ready;
  logic [NTRIG-1:0] trig_req, trig_en, rec_mask;
  logic [7:0] dead_time;
  logic fire_out, busy, rec_valid;
  logic [TS_W-1:0] rec_time;
  logic [3:0] rec_count;
  logic [15:0] drop_count;
`ifdef TRIG_FIRE_SCHED_ROLLING_EN
  logic dorolling = 1'b0;
  logic rec_rolling;
`endif
  int nvec = 0, nfail = 0;
  bit running = 0;
  longint cyc = 0, next_ok = 0, fstart = -1000, mts = 0;
  int occ = 0, drop = 0;
  logic [7:0] m_mask;
  logic [55:0] m_stamp;
  bit live;
  rec_t exp_q[$];

  always #5 clk_adc = ~clk_adc;

  trig_fire_sched dut (
    .clk_adc(clk_adc), .rst(rst), .run_active(run_active), .trig_req(trig_req),
    .trig_en(trig_en), .pass_prescale(pass_prescale), .dead_time(dead_time),
    .ts_clear(ts_clear), .fire_out(fire_out), .busy(busy), .rec_valid(rec_valid),
    .rec_ready(rec_ready), .rec_mask(rec_mask), .rec_time(rec_time), .rec_count(rec_count),
`ifdef TRIG_FIRE_SCHED_ROLLING_EN
    .dorolling(dorolling), .rec_rolling(rec_rolling),
`endif
    .drop_count(drop_count)
  );

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Spec rules as cycle arithmetic: fire starts at cycle F, pulse covers F+1..F+OUT_WIDTH,
  // merge covers F+1..F+MERGE_WIN with the push at F+MERGE_WIN, idle again at F+OUT_WIDTH+1+dead.
  task automatic model_step();
    logic [7:0] q;
    longint k;
    bit push, pop;
    q = (run_active && pass_prescale) ? trig_req & trig_en : 8'h00;
    push = 0;
    if (cyc >= next_ok) begin
      if (q != 8'h00) begin
        fstart = cyc;
        next_ok = longint'(1) << 60;
        m_mask = q;
        m_stamp = mts[55:0];
        live = !ts_clear;
      end
    end else begin
      k = cyc - fstart;
      if (k >= 1 && k <= MERGE_WIN) m_mask |= q;
      if (k == MERGE_WIN && live && !ts_clear) push = 1;
      if (ts_clear) live = 0;
      if (k == OUT_WIDTH) next_ok = cyc + 1 + longint'(dead_time);
    end
    pop = occ > 0 && rec_ready;
    if (ts_clear) begin
      occ = 0;
      drop = 0;
      exp_q.delete();
    end else begin
      if (pop) occ--;
      if (push) begin
        if (occ < DEPTH) begin
          occ++;
          exp_q.push_back('{mask: m_mask, ts: m_stamp, rolling: 1'b0});
        end else if (drop < 65535) drop++;
      end
    end
    mts = ts_clear ? 0 : mts + 1;
    cyc++;
  endtask

  task automatic drive(int i);
    int p;
    p = (i / 400) % 6;
    if (i >= NCYC) begin
      trig_req = 8'h00;
      rec_ready = 1'b1;
      ts_clear = 1'b0;
      run_active = 1'b1;
      pass_prescale = 1'b1;
      return;
    end
    trig_req = (p == 3 && $urandom_range(0, 1) == 0) ? 8'hFF :
               ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
    trig_en = 8'($urandom | $urandom);
    run_active = (p == 3) ? 1'($urandom_range(0, 1)) : 1'b1;
    pass_prescale = (p == 3) ? 1'($urandom_range(0, 1)) : 1'b1;
    rec_ready = (p == 1) ? 1'b0 : (p == 2) ? ($urandom_range(0, 9) < 8) :
                (p == 4) ? ($urandom_range(0, 9) < 3) : 1'($urandom_range(0, 1));
    ts_clear = (p == 4 && $urandom_range(0, 49) == 0) || ($urandom_range(0, 499) == 0);
    dead_time = (p == 5) ? 8'd0 : 8'($urandom_range(0, 12));
  endtask

  always @(negedge clk_adc) begin
    rec_t r;
    if (running) begin
      check("fire_out", 64'(fire_out), 64'(cyc > fstart && cyc <= fstart + OUT_WIDTH));
      check("busy", 64'(busy), 64'(cyc < next_ok));
      check("rec_valid", 64'(rec_valid), 64'(occ > 0));
      check("rec_count", 64'(rec_count), 64'(occ));
      check("drop_count", 64'(drop_count), 64'(drop));
      if (rec_valid && rec_ready) begin
        if (exp_q.size() == 0) check("rec_unexpected", 64'(1), 64'(0));
        else begin
          r = exp_q.pop_front();
          check("rec_mask", 64'(rec_mask), 64'(r.mask));
          check("rec_time", 64'(rec_time), 64'(r.ts));
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    trig_req = '0;
    trig_en = '0;
    run_active = 1'b0;
    pass_prescale = 1'b0;
    ts_clear = 1'b0;
    rec_ready = 1'b0;
    dead_time = '0;
    repeat (3) @(posedge clk_adc);
    @(negedge clk_adc);
    check("rst_fire_out", 64'(fire_out), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_rec_valid", 64'(rec_valid), 64'(0));
    check("rst_rec_count", 64'(rec_count), 64'(0));
    check("rst_drop_count", 64'(drop_count), 64'(0));
    @(posedge clk_adc);
    #1 rst = 1'b0;
    drive(0);
    running = 1;
    for (int i = 1; i <= NCYC + 60; i++) begin
      @(posedge clk_adc);
      model_step();
      #1 drive(i);
    end
    @(negedge clk_adc);
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    running = 0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
